// File: rtl/dcache_pkg.sv
// Shared geometry, line type and FSM encoding for the direct-mapped data cache.
package dcache_pkg;

    localparam int LINE_BYTES = 32;
    localparam int OFFSET_W   = 5;
    localparam int LINE_W     = LINE_BYTES * 8;

    typedef logic [LINE_W-1:0] line_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_e;

    function automatic int index_w(input int num_lines);
        return $clog2(num_lines);
    endfunction

    function automatic int tag_w(input int num_lines);
        return 32 - OFFSET_W - $clog2(num_lines);
    endfunction

endpackage

// File: rtl/dcache_if.sv
// MEM-stage CPU port plus off-chip line-memory port of the data cache.
// slave = cache side, master = pipeline/memory side.
interface dcache_if;
    import dcache_pkg::*;

    logic        cpu_req_i;
    logic        cpu_we_i;
    logic [31:0] cpu_addr_i;
    logic [31:0] cpu_wdata_i;
    logic [31:0] cpu_rdata_o;
    logic        cpu_stall_o;

    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    line_t       mem_wdata_o;
    line_t       mem_rdata_i;
    logic        mem_ack_i;

    modport slave (
        input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
        output cpu_rdata_o, cpu_stall_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  mem_rdata_i, mem_ack_i
    );

    modport master (
        output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
        input  cpu_rdata_o, cpu_stall_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output mem_rdata_i, mem_ack_i
    );

endinterface

// File: rtl/dcache_sram.sv
// Valid/dirty/tag/data arrays: combinational read on index, one write port
// (word store that sets dirty, or full-line fill). Only valid/dirty are reset.
module dcache_sram
    import dcache_pkg::*;
#(
    parameter  int NUM_LINES = 32,
    localparam int IDX_W     = index_w(NUM_LINES),
    localparam int TAG_W     = tag_w(NUM_LINES)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [IDX_W-1:0] idx_i,
    output logic             valid_o,
    output logic             dirty_o,
    output logic [TAG_W-1:0] tag_o,
    output line_t            data_o,
    input  logic             word_we_i,
    input  logic [2:0]       word_sel_i,
    input  logic [31:0]      word_i,
    input  logic             fill_we_i,
    input  logic [TAG_W-1:0] fill_tag_i,
    input  line_t            fill_line_i
);

    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    line_t                data_q [NUM_LINES];

    assign valid_o = valid_q[idx_i];
    assign dirty_o = dirty_q[idx_i];
    assign tag_o   = tag_q[idx_i];
    assign data_o  = data_q[idx_i];

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill_we_i) begin
            valid_q[idx_i] <= 1'b1;
            dirty_q[idx_i] <= 1'b0;
        end else if (word_we_i) begin
            dirty_q[idx_i] <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (fill_we_i) begin
            tag_q[idx_i]  <= fill_tag_i;
            data_q[idx_i] <= fill_line_i;
        end else if (word_we_i) begin
            data_q[idx_i][{word_sel_i, 5'b0} +: 32] <= word_i;
        end
    end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back/write-allocate D-cache: hits in 0 cycles, misses stall
// the pipeline across write-back and fill. DCACHE_STATS_EN adds hit/miss counters.
module dcache_controller
    import dcache_pkg::*;
#(
    parameter int NUM_LINES = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    dcache_if.slave     bus
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0] hit_cnt_o,
    output logic [31:0] miss_cnt_o
`endif
);

    localparam int IDX_W = index_w(NUM_LINES);
    localparam int TAG_W = tag_w(NUM_LINES);

    state_e           state_q, state_d;
    logic [31:0]      mem_addr_q, mem_addr_d;
    line_t            mem_wdata_q, mem_wdata_d;

    logic [IDX_W-1:0] cpu_idx;
    logic [TAG_W-1:0] cpu_tag;
    logic [2:0]       cpu_word;
    logic             line_valid;
    logic             line_dirty;
    logic [TAG_W-1:0] line_tag;
    line_t            line_data;
    logic             idle;
    logic             hit;
    logic             store_hit;
    logic             fill;
    logic             unused_addr_lsb;

    assign cpu_idx         = bus.cpu_addr_i[OFFSET_W +: IDX_W];
    assign cpu_tag         = bus.cpu_addr_i[31 -: TAG_W];
    assign cpu_word        = bus.cpu_addr_i[4:2];
    assign unused_addr_lsb = ^bus.cpu_addr_i[1:0];

    assign idle      = (state_q == IDLE);
    assign hit       = line_valid && (line_tag == cpu_tag);
    assign store_hit = idle && bus.cpu_req_i && bus.cpu_we_i && hit;
    assign fill      = (state_q == ALLOCATE) && bus.mem_ack_i;

    // The pipeline holds cpu_addr_i while stalled, so the fill can use its index.
    dcache_sram #(.NUM_LINES(NUM_LINES)) u_sram (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .idx_i       (cpu_idx),
        .valid_o     (line_valid),
        .dirty_o     (line_dirty),
        .tag_o       (line_tag),
        .data_o      (line_data),
        .word_we_i   (store_hit),
        .word_sel_i  (cpu_word),
        .word_i      (bus.cpu_wdata_i),
        .fill_we_i   (fill),
        .fill_tag_i  (cpu_tag),
        .fill_line_i (bus.mem_rdata_i)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.cpu_req_i && !hit) begin
                    state_d = (line_valid && line_dirty) ? WRITEBACK : ALLOCATE;
                end
            end
            WRITEBACK: if (bus.mem_ack_i) state_d = ALLOCATE;
            ALLOCATE:  if (bus.mem_ack_i) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Memory-side address/data are captured on entry to each transaction so that
    // mem_* never depends combinationally on the CPU port.
    always_comb begin
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (idle && state_d == WRITEBACK) begin
            mem_addr_d  = {line_tag, cpu_idx, {OFFSET_W{1'b0}}};
            mem_wdata_d = line_data;
        end else if (state_q != ALLOCATE && state_d == ALLOCATE) begin
            mem_addr_d  = {cpu_tag, cpu_idx, {OFFSET_W{1'b0}}};
        end

        bus.cpu_stall_o = bus.cpu_req_i && (!idle || !hit);
        bus.cpu_rdata_o = line_data[{cpu_word, 5'b0} +: 32];
        bus.mem_req_o   = !idle;
        bus.mem_we_o    = (state_q == WRITEBACK);
        bus.mem_addr_o  = mem_addr_q;
        bus.mem_wdata_o = mem_wdata_q;
    end

`ifdef DCACHE_STATS_EN
    logic        fill_done_q;
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;

    // The access completing a fill is already counted as a miss.
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (idle && bus.cpu_req_i && hit && !fill_done_q && hit_cnt_q != '1) begin
            hit_cnt_d = hit_cnt_q + 32'd1;
        end
        if (idle && bus.cpu_req_i && !hit && miss_cnt_q != '1) begin
            miss_cnt_d = miss_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            fill_done_q <= 1'b0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
        end else begin
            fill_done_q <= fill;
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// Randomised scoreboard bench for dcache_controller against a line-level cache model.
`timescale 1ns/1ps
module tb_dcache_controller;
    import dcache_pkg::*;

    localparam int NUM_LINES = 32;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        line_t       data;
    } txn_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dcache_if bus();

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    dcache_controller #(.NUM_LINES(NUM_LINES)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
`ifdef DCACHE_STATS_EN
        ,
        .hit_cnt_o  (hit_cnt),
        .miss_cnt_o (miss_cnt)
`endif
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: backing memory of words plus per-slot line copies.
    logic [31:0] ref_mem  [int unsigned];
    logic [31:0] phys_mem [int unsigned];
    bit          m_valid  [NUM_LINES];
    bit          m_dirty  [NUM_LINES];
    logic [31:0] m_base   [NUM_LINES];
    logic [31:0] m_words  [NUM_LINES][8];
    txn_t        exp_mem[$];
    logic [31:0] exp_load[$];

    // Unwritten memory: word k of line L holds 4*L + k (line 0x40 -> 0x100+k).
    function automatic logic [31:0] init_word(input logic [31:0] a);
        return ((a & ~32'h1F) << 2) + ((a >> 2) & 32'd7);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        int unsigned k;
        k = a >> 2;
        return ref_mem.exists(k) ? ref_mem[k] : init_word(a);
    endfunction

    function automatic logic [31:0] phys_rd(input logic [31:0] a);
        int unsigned k;
        k = a >> 2;
        return phys_mem.exists(k) ? phys_mem[k] : init_word(a);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_LINES; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
    endtask

    task automatic model_access(input bit we, input logic [31:0] addr,
                                input logic [31:0] wdata, output int n_txn);
        logic [31:0] base;
        int          slot;
        int          w;
        txn_t        t;
        base  = addr & ~32'h1F;
        slot  = int'((addr >> 5) % NUM_LINES);
        w     = int'((addr >> 2) % 8);
        n_txn = 0;
        if (!(m_valid[slot] && m_base[slot] == base)) begin
            if (m_valid[slot] && m_dirty[slot]) begin
                t.we   = 1'b1;
                t.addr = m_base[slot];
                for (int k = 0; k < 8; k++) begin
                    t.data[32*k +: 32] = m_words[slot][k];
                    ref_mem[(m_base[slot] >> 2) + k] = m_words[slot][k];
                end
                exp_mem.push_back(t);
                n_txn++;
            end
            t.we   = 1'b0;
            t.addr = base;
            t.data = '0;
            exp_mem.push_back(t);
            n_txn++;
            for (int k = 0; k < 8; k++) m_words[slot][k] = ref_rd(base + 32'(4 * k));
            m_valid[slot] = 1'b1;
            m_dirty[slot] = 1'b0;
            m_base[slot]  = base;
        end
        if (we) begin
            m_words[slot][w] = wdata;
            m_dirty[slot]    = 1'b1;
        end else begin
            exp_load.push_back(m_words[slot][w]);
        end
    endtask

    // Memory responder: acks each transaction after ack_dly waiting cycles.
    int ack_dly  = 0;
    int wait_cnt = 0;
    bit spurious = 1'b0;

    initial begin
        bus.mem_ack_i   = 1'b0;
        bus.mem_rdata_i = '0;
        forever begin
            @(posedge clk); #1;
            bus.mem_ack_i = 1'b0;
            if (!rst_n) begin
                wait_cnt = 0;
            end else if (spurious) begin
                bus.mem_ack_i = 1'b1;
                spurious      = 1'b0;
            end else if (bus.mem_req_o) begin
                if (wait_cnt >= ack_dly) begin
                    wait_cnt      = 0;
                    bus.mem_ack_i = 1'b1;
                    for (int k = 0; k < 8; k++) begin
                        if (bus.mem_we_o)
                            phys_mem[(bus.mem_addr_o >> 2) + k] = bus.mem_wdata_o[32*k +: 32];
                        else
                            bus.mem_rdata_i[32*k +: 32] = phys_rd(bus.mem_addr_o + 32'(4 * k));
                    end
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Load-data monitor.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && bus.cpu_req_i && !bus.cpu_we_i && !bus.cpu_stall_o) begin
                if (exp_load.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL load_unexpected: got %h expected no load", bus.cpu_rdata_o);
                end else begin
                    check("load_data", bus.cpu_rdata_o, exp_load.pop_front());
                end
            end
        end
    end

    // Memory-transaction monitor: stability while waiting, contents at ack.
    bit          prev_v = 1'b0;
    bit          prev_we;
    logic [31:0] prev_addr;
    line_t       prev_wd;
    txn_t        got_t;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n || !bus.mem_req_o) begin
                prev_v = 1'b0;
            end else begin
                if (prev_v) begin
                    check("mem_addr_stable", bus.mem_addr_o, prev_addr);
                    check("mem_we_stable", bus.mem_we_o, prev_we);
                    if (prev_we) check("mem_wdata_stable", bus.mem_wdata_o, prev_wd);
                end
                if (bus.mem_ack_i) begin
                    prev_v = 1'b0;
                    if (exp_mem.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL mem_txn_unexpected: got we=%0b addr=%h expected none",
                                 bus.mem_we_o, bus.mem_addr_o);
                    end else begin
                        got_t = exp_mem.pop_front();
                        check("mem_we", bus.mem_we_o, got_t.we);
                        check("mem_addr", bus.mem_addr_o, got_t.addr);
                        if (got_t.we) check("mem_wdata", bus.mem_wdata_o, got_t.data);
                    end
                end else begin
                    prev_v    = 1'b1;
                    prev_we   = bus.mem_we_o;
                    prev_addr = bus.mem_addr_o;
                    prev_wd   = bus.mem_wdata_o;
                end
            end
        end
    end

    // One CPU access; caller is positioned just after a rising edge.
    task automatic access(input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, input int dly);
        int n_txn;
        int exp_stall;
        int stalls;
        model_access(we, addr, wdata, n_txn);
        exp_stall = (n_txn == 0) ? 0 : 1 + n_txn * (dly + 1);
        ack_dly         = dly;
        bus.cpu_req_i   = 1'b1;
        bus.cpu_we_i    = we;
        bus.cpu_addr_i  = addr;
        bus.cpu_wdata_i = wdata;
        stalls = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (!bus.cpu_stall_o) break;
            stalls++;
        end
        check("stall_cycles", 256'(stalls), 256'(exp_stall));
        @(posedge clk); #1;
        bus.cpu_req_i = 1'b0;
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        bus.cpu_req_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    logic [31:0] ra;

    initial begin
        rst_n           = 1'b0;
        bus.cpu_req_i   = 1'b0;
        bus.cpu_we_i    = 1'b0;
        bus.cpu_addr_i  = '0;
        bus.cpu_wdata_i = '0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_stall", bus.cpu_stall_o, 1'b0);
        check("rst_mem_req", bus.mem_req_o, 1'b0);
        check("rst_mem_we", bus.mem_we_o, 1'b0);
        check("rst_mem_addr", bus.mem_addr_o, 32'h0);
        check("rst_mem_wdata", bus.mem_wdata_o, 256'h0);
`ifdef DCACHE_STATS_EN
        check("rst_hit_cnt", hit_cnt, 32'h0);
        check("rst_miss_cnt", miss_cnt, 32'h0);
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Cold load, store hit, dirty conflict, then hit on the new line.
        access(1'b0, 32'h0000_0040, 32'h0, 3);
        access(1'b1, 32'h0000_0044, 32'hDEAD_BEEF, 0);
        access(1'b0, 32'h0000_0044, 32'h0, 0);
        access(1'b0, 32'h0000_0440, 32'h0, 2);
        access(1'b0, 32'h0000_0440, 32'h0, 0);

        // Slow memory: fill held off for 10 cycles.
        access(1'b0, 32'h0000_1080, 32'h0, 10);

        // Spurious ack in IDLE must not disturb anything.
        @(negedge clk);
        spurious = 1'b1;
        @(negedge clk);
        check("spurious_ack_seen", bus.mem_ack_i, 1'b1);
        check("spurious_mem_req", bus.mem_req_o, 1'b0);
        @(negedge clk);
        check("spurious_after_req", bus.mem_req_o, 1'b0);
        @(posedge clk); #1;
        access(1'b0, 32'h0000_1084, 32'h0, 0);

        // Random traffic over a few indices and tags to force conflicts.
        for (int i = 0; i < 300; i++) begin
            ra = (32'($urandom_range(0, 1)) << 31) | (32'($urandom_range(0, 3)) << 10)
               | (32'($urandom_range(0, 3)) << 5) | (32'($urandom_range(0, 7)) << 2)
               | 32'($urandom_range(0, 3));
            access(1'($urandom_range(0, 1)), ra, $urandom, int'($urandom_range(0, 3)));
        end

        // Reset while a write-back is outstanding.
        do_reset();
        access(1'b1, 32'h0000_0040, 32'hCAFE_F00D, 0);
        ack_dly         = 1000;
        bus.cpu_req_i   = 1'b1;
        bus.cpu_we_i    = 1'b0;
        bus.cpu_addr_i  = 32'h0000_0440;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.mem_req_o && bus.mem_we_o) break;
        end
        check("wb_started", {bus.mem_req_o, bus.mem_we_o}, 2'b11);
        check("wb_addr", bus.mem_addr_o, 32'h0000_0040);
        check("wb_word0", bus.mem_wdata_o[31:0], 32'hCAFE_F00D);
        #2;
        rst_n         = 1'b0;
        bus.cpu_req_i = 1'b0;
        #1;
        check("rst_async_mem_req", bus.mem_req_o, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        access(1'b0, 32'h0000_0040, 32'h0, 1);

`ifdef DCACHE_STATS_EN
        do_reset();
        access(1'b0, 32'h0000_0040, 32'h0, 1);
        access(1'b1, 32'h0000_0044, 32'h1234_5678, 0);
        access(1'b0, 32'h0000_0048, 32'h0, 0);
        access(1'b0, 32'h0000_0440, 32'h0, 1);
        @(negedge clk);
        check("stats_miss_cnt", miss_cnt, 32'd2);
        check("stats_hit_cnt", hit_cnt, 32'd2);
`endif

        repeat (3) @(posedge clk);
        check("load_queue_drained", 256'(exp_load.size()), 256'(0));
        check("mem_queue_drained", 256'(exp_mem.size()), 256'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
